// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the load/store unit
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam int BE_W = 4;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_aligned(input mem_op_e op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return (a[0] == 1'b0);
            OP_LW, OP_SW:         return (a == 2'b00);
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane select with sign/zero extension
module load_extend
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  mem_op_e        mem_op,
    input  logic [1:0]     addr,
    input  logic [N-1:0]   bus_rdata,
    output logic [N-1:0]   result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = bus_rdata[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (mem_op)
            OP_LB:   result = {{(N-8){lane_b[7]}}, lane_b};
            OP_LBU:  result = {{(N-8){1'b0}}, lane_b};
            OP_LH:   result = {{(N-16){lane_h[15]}}, lane_h};
            OP_LHU:  result = {{(N-16){1'b0}}, lane_h};
            default: result = bus_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store engine over a req/ack bus
module load_store_unit
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [2:0]      mem_op,
    input  logic [N-1:0]    addr,
    input  logic [N-1:0]    wdata,
    output logic            busy,
    output logic [N-1:0]    rdata,
    output logic            rdata_valid,
    output logic            misaligned,
    output logic            bus_req,
    output logic            bus_we,
    output logic [N-1:0]    bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [N-1:0]    bus_wdata,
    input  logic            bus_ack,
    input  logic [N-1:0]    bus_rdata
);

    generate
        if (N != 32) begin : g_bad_width
            $error("load_store_unit supports only N = 32");
        end
    endgenerate

    lsu_state_e state;
    mem_op_e    op;
    mem_op_e    op_q;
    logic [1:0] lane_q;
    logic       aligned;
    logic [BE_W-1:0] be_calc;
    logic [N-1:0]    wdata_calc;
    logic [N-1:0]    load_ext;

    assign op      = mem_op_e'(mem_op);
    assign aligned = is_aligned(op, addr[1:0]);

    assign busy       = (state == BUS) || ((state == IDLE) && req_valid && aligned);
    assign misaligned = (state == IDLE) && req_valid && !aligned;

    // Byte enables and replicated store data derive from the raw request so
    // they can be latched on the same edge that leaves IDLE.
    always_comb begin
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata;
            end
        endcase
    end

    load_extend #(.N(N)) u_load_extend (
        .mem_op    (op_q),
        .addr      (lane_q),
        .bus_rdata (bus_rdata),
        .result    (load_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_LB;
            lane_q      <= 2'b00;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && aligned) begin
                        state     <= BUS;
                        op_q      <= op;
                        lane_q    <= addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= is_store(op);
                        bus_addr  <= {addr[N-1:2], 2'b00};
                        bus_be    <= be_calc;
                        bus_wdata <= wdata_calc;
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        state   <= RESP;
                        bus_req <= 1'b0;
                        if (!is_store(op_q)) begin
                            rdata       <= load_ext;
                            rdata_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.N(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .mem_op      (mem_op),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misaligned  (misaligned),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input mem_op_e op, input logic [31:0] a, input logic [31:0] wd);
        req_valid = v;
        mem_op    = op;
        addr      = a;
        wdata     = wd;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        mem_op    = 3'b000;
        addr      = '0;
        wdata     = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;

        next_cycle();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_misal", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // LW 0x100, ack k=2
        next_cycle();
        set_req(1'b1, OP_LW, 32'h0000_0100, 32'h0);
        #1;
        chk("lw_c0_busy", {31'd0, busy}, 32'd1);
        chk("lw_c0_bus_req", {31'd0, bus_req}, 32'd0);
        next_cycle();
        chk("lw_c1_bus_req", {31'd0, bus_req}, 32'd1);
        chk("lw_c1_busy", {31'd0, busy}, 32'd1);
        chk("lw_c1_bus_be", {28'd0, bus_be}, 32'hF);
        chk("lw_c1_bus_addr", bus_addr, 32'h0000_0100);
        chk("lw_c1_bus_we", {31'd0, bus_we}, 32'd0);
        next_cycle();
        chk("lw_c2_busy", {31'd0, busy}, 32'd1);
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        chk("lw_c3_busy", {31'd0, busy}, 32'd1);
        chk("lw_c3_rvalid", {31'd0, rdata_valid}, 32'd0);
        next_cycle();
        bus_ack = 1'b0;
        chk("lw_c4_rvalid", {31'd0, rdata_valid}, 32'd1);
        chk("lw_c4_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_c4_busy", {31'd0, busy}, 32'd0);
        chk("lw_c4_bus_req", {31'd0, bus_req}, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        #1;
        chk("lw_c5_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("lw_c5_rdata_hold", rdata, 32'hDEAD_BEEF);

        // LB 0x203 then LBU 0x203, ack k=0
        next_cycle();
        set_req(1'b1, OP_LB, 32'h0000_0203, 32'h0);
        next_cycle();
        chk("lb_bus_be", {28'd0, bus_be}, 32'h8);
        chk("lb_bus_addr", bus_addr, 32'h0000_0200);
        bus_ack   = 1'b1;
        bus_rdata = 32'h80FF_FF7F;
        next_cycle();
        bus_ack = 1'b0;
        chk("lb_rvalid", {31'd0, rdata_valid}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        next_cycle();
        set_req(1'b1, OP_LBU, 32'h0000_0203, 32'h0);
        next_cycle();
        bus_ack = 1'b1;
        next_cycle();
        bus_ack = 1'b0;
        chk("lbu_rdata", rdata, 32'h0000_0080);
        next_cycle();
        req_valid = 1'b0;

        // SH 0x102, ack k=0
        next_cycle();
        set_req(1'b1, OP_SH, 32'h0000_0102, 32'h1234_ABCD);
        next_cycle();
        chk("sh_bus_addr", bus_addr, 32'h0000_0100);
        chk("sh_bus_we", {31'd0, bus_we}, 32'd1);
        chk("sh_bus_be", {28'd0, bus_be}, 32'hC);
        chk("sh_bus_wdata", bus_wdata, 32'hABCD_ABCD);
        bus_ack   = 1'b1;
        bus_rdata = 32'h5A5A_5A5A;
        next_cycle();
        bus_ack = 1'b0;
        chk("sh_resp_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("sh_resp_busy", {31'd0, busy}, 32'd0);
        chk("sh_rdata_hold", rdata, 32'h0000_0080);
        next_cycle();
        req_valid = 1'b0;

        // Misaligned LW 0x101
        next_cycle();
        set_req(1'b1, OP_LW, 32'h0000_0101, 32'h0);
        #1;
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        #1;
        chk("mis_bus_req", {31'd0, bus_req}, 32'd0);
        chk("mis_flag_drop", {31'd0, misaligned}, 32'd0);

        // LH 0x0 sign-extends the low half
        next_cycle();
        set_req(1'b1, OP_LH, 32'h0000_0000, 32'h0);
        next_cycle();
        chk("lh_bus_be", {28'd0, bus_be}, 32'h3);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_8001;
        next_cycle();
        bus_ack = 1'b0;
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        next_cycle();
        req_valid = 1'b0;

        // Reset during BUS of an LW abandons it
        next_cycle();
        set_req(1'b1, OP_LW, 32'h0000_0200, 32'h0);
        next_cycle();
        chk("rstmid_bus_req_pre", {31'd0, bus_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        next_cycle();
        reset     = 1'b0;
        req_valid = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        next_cycle();
        bus_ack = 1'b0;
        chk("rstmid_no_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("rstmid_rdata_kept", rdata, 32'd0);

        // SB 0x3 after reset
        next_cycle();
        set_req(1'b1, OP_SB, 32'h0000_0003, 32'h0000_0055);
        next_cycle();
        chk("sb_bus_be", {28'd0, bus_be}, 32'h8);
        chk("sb_bus_wdata", bus_wdata, 32'h5555_5555);
        chk("sb_bus_we", {31'd0, bus_we}, 32'd1);
        bus_ack = 1'b1;
        next_cycle();
        bus_ack = 1'b0;
        chk("sb_resp_rvalid", {31'd0, rdata_valid}, 32'd0);
        next_cycle();
        req_valid = 1'b0;

        // Spurious ack in IDLE
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_1111;
        next_cycle();
        bus_ack = 1'b0;
        chk("spur_idle_bus_req", {31'd0, bus_req}, 32'd0);
        chk("spur_idle_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("spur_idle_rdata", rdata, 32'd0);

        // LHU 0x2, then spurious ack during RESP
        next_cycle();
        set_req(1'b1, OP_LHU, 32'h0000_0002, 32'h0);
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'hBEEF_0000;
        next_cycle();
        bus_rdata = 32'h1234_5678;
        chk("lhu_rdata", rdata, 32'h0000_BEEF);
        next_cycle();
        bus_ack   = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("spur_resp_bus_req", {31'd0, bus_req}, 32'd0);
        chk("spur_resp_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("spur_resp_rdata", rdata, 32'h0000_BEEF);
        chk("spur_resp_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        chk("spur_resp_idle", {31'd0, bus_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage downstream of the MIPS ALU. It takes the ALU result as the effective address and runs one load or store per request over a simple req/ack data bus. It handles byte-lane steering, load sign/zero extension and misalignment detection, and stalls the core with `busy` until the access completes.

## Interface
- `N`, 32, datapath width; only 32 is supported (elaboration-time assertion).
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces idle immediately.
- `req_valid`  in  1  core requests a memory op; held stable while `busy`=1.
- `mem_op`  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- `addr`  in  N  effective address (ALU output), byte address.
- `wdata`  in  N  store data (rt), right-justified.
- `busy`  out  1  stall request to the core.
- `rdata`  out  N  extended load result.
- `rdata_valid`  out  1  one-cycle pulse; `rdata` is valid.
- `misaligned`  out  1  one-cycle pulse; request rejected.
- `bus_req`  out  1  bus transaction active.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  N  word-aligned address, `{addr[N-1:2],2'b00}`.
- `bus_be`  out  4  byte enables; bit i = byte lane i, little-endian.
- `bus_wdata`  out  N  lane-replicated store data.
- `bus_ack`  in  1  single-cycle completion pulse from the bus.
- `bus_rdata`  in  N  read word; valid in the `bus_ack` cycle.

## Operation
- FSM states:
  - IDLE → BUS on `req_valid` with an aligned address. Op, address, byte enables and write data are latched on this edge.
  - BUS → RESP on `bus_ack`. For loads, `rdata` is captured, already extended, on this edge.
  - RESP → IDLE unconditionally.
- Alignment rules:
  - LH/LHU/SH need `addr[0]`=0.
  - LW/SW need `addr[1:0]`=0.
  - Byte ops are always aligned.
- Misaligned request in IDLE:
  - `misaligned`=1 combinationally that cycle, `busy`=0, no bus activity, state stays IDLE.
  - The core is responsible for taking the exception.
- Byte enables:
  - Byte ops: `1<<addr[1:0]`.
  - Halfword ops: `addr[1]` ? 1100 : 0011.
  - Word ops: 1111.
  - Loads drive `bus_be` as well.
- Store data: byte ops replicate `wdata[7:0]` ×4; halfword ops replicate `wdata[15:0]` ×2; SW passes `wdata` through.
- Load extraction:
  - LB/LBU select lane `addr[1:0]`; LH/LHU select lane `addr[1]`.
  - LB/LH sign-extend to N; LBU/LHU zero-extend.
- Bus behaviour in BUS:
  - `bus_req`=1, with `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` driven from registers and stable until `bus_ack`.
  - Only one transaction is outstanding at a time.
- Flags in RESP:
  - `rdata_valid`=1 for loads, 0 for stores.
  - `busy`=0 so the core advances on this edge.
  - `req_valid`, still high for the completing instruction, is ignored.
- `bus_ack` while in IDLE or RESP is ignored.
- `rdata` holds its last load value until the next load completes.

## Timing
- `busy` = (state==BUS) | (state==IDLE & `req_valid` & aligned). It is combinational in the request cycle and low in RESP.
- Access with `bus_ack` k cycles after `bus_req` rises (k ≥ 0):
  - cycle 0: request, IDLE;
  - cycles 1..1+k: BUS;
  - cycle 2+k: RESP.
  - Minimum total is 3 cycles.
- `bus_ack` in the first BUS cycle is legal and gives k = 0.
- Reset values:
  - state IDLE;
  - `rdata` 0;
  - `bus_req`, `bus_we`, `bus_be`, `bus_addr` and `bus_wdata` all 0;
  - `rdata_valid`, `misaligned` and `busy` all 0.
- Reset asserted mid-access:
  - `bus_req` drops in the same cycle without waiting for a clock edge.
  - The pending access is abandoned; no `rdata_valid` is produced.
- Outputs affected by `reset` are driven from registers; `busy` and `misaligned` are combinational from registered state and inputs.

## Structure
- Shared package `mem_pkg`:
  - `mem_op_e` enum with the eight encodings above;
  - `lsu_state_e` enum {IDLE, BUS, RESP};
  - `BE_W`=4 constant.
- Helper functions in the same package:
  - `is_store(mem_op_e)`;
  - `is_aligned(mem_op_e, logic[1:0])`.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension. Inputs: `mem_op`, `addr[1:0]`, `bus_rdata`. Output: N-bit result. It is instantiated once and used at the `bus_ack` edge.

## Test plan
- LW at 0x0000_0100, `bus_rdata` 0xDEAD_BEEF, ack 2 cycles after `bus_req` → `busy` high for 4 cycles; `rdata_valid` pulse in cycle 4 with `rdata`=0xDEAD_BEEF; `bus_be`=1111.
- LB at 0x0000_0203, `bus_rdata` 0x80FF_FF7F → `bus_be`=1000, `rdata`=0xFFFF_FF80. The same access as LBU → `rdata`=0x0000_0080.
- SH at 0x0000_0102, `wdata` 0x1234_ABCD, ack k=0 → `bus_addr`=0x100, `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCD_ABCD; RESP follows with `rdata_valid`=0.
- LW at 0x0000_0101 → `misaligned`=1 for one cycle, `busy`=0, `bus_req` never rises, state stays IDLE.
- Reset pulsed during BUS of an LW → `bus_req`=0 immediately, no `rdata_valid`. A subsequent SB at 0x3, `wdata` 0x55 completes with `bus_be`=1000 and `bus_wdata`=0x5555_5555.
- Spurious `bus_ack` pulses in IDLE and in RESP → no state change, no `rdata` update.
